// File: rtl/dmem_port_arbiter.sv
// Single-port D-cache arbiter. Loads come from the load buffer and stores
// come from ROB commit. The winner's request is latched, held on the cache
// port until dmem_resp_i, and the response is steered back to that winner.
// A store normally beats a waiting load. After STARVE_MAX store grants in a
// row while a load is waiting, the load is given the port.
// A flush during a load lets the cache finish, then throws the data away.
//
// Handshake: each requester holds its request level-high until it sees its
// 1-cycle resp pulse, and drops the request on the edge after that pulse.
// On the cache side, dmem_read_o/dmem_write_o stay high until the cache
// answers with a 1-cycle dmem_resp_i pulse.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              ld_read_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              ld_resp_o,
   output logic [DATA_W-1:0] ld_rdata_o,
   input  logic              st_write_i,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_wdata_i,
   input  logic [1:0]        st_wmask_i,
   output logic              st_resp_o,
   output logic              dmem_read_o,
   output logic              dmem_write_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   output logic [1:0]        dmem_wmask_o,
   input  logic              dmem_resp_i,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LD_BUSY  = 2'd1,
      ST_BUSY  = 2'd2,
      LD_DRAIN = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        wmask_q, wmask_d;

   logic ld_elig;
   logic st_wins;

   // A load is held off by a flush. A store wins unless the load has
   // already been skipped for STARVE_MAX store grants in a row.
   assign ld_elig = ld_read_i && !flush_i;
   assign st_wins = st_write_i && !(ld_elig && (starve_q == CNT_MAX));

   // Next-state, latch updates and all outputs, decoded from the current state
   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      ld_resp_o    = 1'b0;
      ld_rdata_o   = '0;
      st_resp_o    = 1'b0;
      dmem_read_o  = 1'b0;
      dmem_write_o = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      dmem_wmask_o = 2'b00;

      case (state_q)
         IDLE: begin
            if (st_wins) begin
               state_d = ST_BUSY;
               addr_d  = st_addr_i;
               wdata_d = st_wdata_i;
               wmask_d = st_wmask_i;
               if (ld_read_i) begin
                  starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
               end else begin
                  starve_d = '0;
               end
            end else if (ld_elig) begin
               state_d  = LD_BUSY;
               addr_d   = ld_addr_i;
               wdata_d  = '0;
               wmask_d  = 2'b00;
               starve_d = '0;
            end else if (!ld_read_i) begin
               starve_d = '0;
            end
         end
         LD_BUSY: begin
            dmem_read_o = 1'b1;
            dmem_addr_o = addr_q;
            if (dmem_resp_i) begin
               state_d = IDLE;
               // A flush landing together with the response kills the response
               if (!flush_i) begin
                  ld_resp_o  = 1'b1;
                  ld_rdata_o = dmem_rdata_i;
               end
            end else if (flush_i) begin
               state_d = LD_DRAIN;
            end
         end
         LD_DRAIN: begin
            // The cache must see the read held until it answers. The data is then dropped.
            dmem_read_o = 1'b1;
            dmem_addr_o = addr_q;
            if (dmem_resp_i) begin
               state_d = IDLE;
            end
         end
         ST_BUSY: begin
            // A committed store always completes. Flush has no effect here.
            dmem_write_o = 1'b1;
            dmem_addr_o  = addr_q;
            dmem_wdata_o = wdata_q;
            dmem_wmask_o = wmask_q;
            if (dmem_resp_i) begin
               st_resp_o = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o  = (state_q != IDLE);
   assign state_o = state_q;

   // State, starvation counter and latched request registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         starve_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter.
// exp_q holds the expected cache commands in expected grant order, packed as
// {write, addr, wdata, wmask}. resp_q holds the expected requester-side
// response {ld_resp, st_resp, ld_rdata} for each dmem_resp pulse the bench drives.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        ld_read;
   logic [15:0] ld_addr;
   logic        ld_resp;
   logic [15:0] ld_rdata;
   logic        st_write;
   logic [15:0] st_addr;
   logic [15:0] st_wdata;
   logic [1:0]  st_wmask;
   logic        st_resp;
   logic        dmem_read;
   logic        dmem_write;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [1:0]  dmem_wmask;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;
   logic        busy;
   logic [1:0]  state;

   logic [34:0] exp_q[$];
   logic [17:0] resp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .flush_i      (flush),
      .ld_read_i    (ld_read),
      .ld_addr_i    (ld_addr),
      .ld_resp_o    (ld_resp),
      .ld_rdata_o   (ld_rdata),
      .st_write_i   (st_write),
      .st_addr_i    (st_addr),
      .st_wdata_i   (st_wdata),
      .st_wmask_i   (st_wmask),
      .st_resp_o    (st_resp),
      .dmem_read_o  (dmem_read),
      .dmem_write_o (dmem_write),
      .dmem_addr_o  (dmem_addr),
      .dmem_wdata_o (dmem_wdata),
      .dmem_wmask_o (dmem_wmask),
      .dmem_resp_i  (dmem_resp),
      .dmem_rdata_i (dmem_rdata),
      .busy_o       (busy),
      .state_o      (state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ld(input logic [15:0] a);
      ld_read = 1'b1;
      ld_addr = a;
   endtask

   task automatic exp_ld(input logic [15:0] a);
      exp_q.push_back({1'b0, a, 16'h0000, 2'b00});
   endtask

   task automatic set_st(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
      st_write = 1'b1;
      st_addr  = a;
      st_wdata = d;
      st_wmask = m;
   endtask

   task automatic exp_st(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
      exp_q.push_back({1'b1, a, d, m});
   endtask

   // Wait (bounded) for the next cache command and compare it with the queue
   // head. The request is driven just after an edge, so the command must
   // appear after exactly one more edge.
   task automatic wait_cmd(input string tag);
      logic        found;
      int          lat;
      logic [34:0] e;
      found = 1'b0;
      lat   = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (dmem_read || dmem_write) begin
            found = 1'b1;
            lat   = i;
         end
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h0;
      check({tag, " cmd_seen"}, 32'(found), 32'd1);
      if (found) begin
         check({tag, " latency"}, 32'(lat), 32'd1);
         check({tag, " dmem_read"}, 32'(dmem_read), 32'(!e[34]));
         check({tag, " dmem_write"}, 32'(dmem_write), 32'(e[34]));
         check({tag, " dmem_addr"}, 32'(dmem_addr), 32'(e[33:18]));
         check({tag, " dmem_wdata"}, 32'(dmem_wdata), 32'(e[17:2]));
         check({tag, " dmem_wmask"}, 32'(dmem_wmask), 32'(e[1:0]));
         check({tag, " busy"}, 32'(busy), 32'd1);
      end
   endtask

   // After n edges, pulse dmem_resp for one cycle and compare the requester response
   task automatic respond(input string tag, input int n, input logic [15:0] rdata,
                          input logic e_ld, input logic e_st, input logic [15:0] e_rd);
      logic [17:0] e;
      repeat (n) tick();
      dmem_resp  = 1'b1;
      dmem_rdata = rdata;
      resp_q.push_back({e_ld, e_st, e_rd});
      @(negedge clk);
      e = resp_q.pop_front();
      check({tag, " ld_resp"}, 32'(ld_resp), 32'(e[17]));
      check({tag, " st_resp"}, 32'(st_resp), 32'(e[16]));
      check({tag, " ld_rdata"}, 32'(ld_rdata), 32'(e[15:0]));
      check({tag, " rd_wr_excl"}, 32'(dmem_read && dmem_write), 32'd0);
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0000;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      ld_read = 1'b0; ld_addr = 16'h0;
      st_write = 1'b0; st_addr = 16'h0; st_wdata = 16'h0; st_wmask = 2'b00;
      dmem_resp = 1'b0; dmem_rdata = 16'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst state", 32'(state), 32'd0);
      check("rst dmem_read", 32'(dmem_read), 32'd0);
      check("rst dmem_write", 32'(dmem_write), 32'd0);
      check("rst dmem_addr", 32'(dmem_addr), 32'd0);
      check("rst dmem_wdata", 32'(dmem_wdata), 32'd0);
      check("rst dmem_wmask", 32'(dmem_wmask), 32'd0);
      check("rst ld_resp", 32'(ld_resp), 32'd0);
      check("rst st_resp", 32'(st_resp), 32'd0);
      check("rst ld_rdata", 32'(ld_rdata), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // 1: plain load, answered in the third busy cycle
      set_ld(16'h1234); exp_ld(16'h1234);
      wait_cmd("t1");
      respond("t1", 2, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF);
      ld_read = 1'b0;
      @(negedge clk);
      check("t1 idle busy", 32'(busy), 32'd0);
      tick();

      // 2: store and load arrive together; the store goes first
      set_st(16'h0040, 16'hA5A5, 2'b10); exp_st(16'h0040, 16'hA5A5, 2'b10);
      set_ld(16'h0080); exp_ld(16'h0080);
      wait_cmd("t2 st");
      respond("t2 st", 1, 16'hDEAD, 1'b0, 1'b1, 16'h0000);
      st_write = 1'b0;
      wait_cmd("t2 ld");
      respond("t2 ld", 1, 16'h0042, 1'b1, 1'b0, 16'h0042);
      ld_read = 1'b0;
      tick();

      // 3: back-to-back stores with a load held; four stores, then the load
      set_ld(16'h0100);
      for (int k = 0; k < 4; k++) begin
         set_st(16'h0200 + 16'(k), 16'h1000 + 16'(k), 2'(k));
         exp_st(16'h0200 + 16'(k), 16'h1000 + 16'(k), 2'(k));
         wait_cmd("t3 st");
         respond("t3 st", 1, 16'h0000, 1'b0, 1'b1, 16'h0000);
      end
      exp_ld(16'h0100);
      set_st(16'h0300, 16'h2222, 2'b11); exp_st(16'h0300, 16'h2222, 2'b11);
      wait_cmd("t3 ld");
      respond("t3 ld", 1, 16'h3C3C, 1'b1, 1'b0, 16'h3C3C);
      ld_read = 1'b0;
      wait_cmd("t3 st5");
      respond("t3 st5", 1, 16'h0000, 1'b0, 1'b1, 16'h0000);
      st_write = 1'b0;
      tick();

      // flush in IDLE blocks the load grant for that cycle only
      set_ld(16'h0400); flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_ld(16'h0400);
      wait_cmd("t7 flush_idle");

      // 4: flush during LD_BUSY drains the load silently
      tick();
      flush = 1'b1; ld_read = 1'b0;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("t4 state drain", 32'(state), 32'd3);
      check("t4 dmem_read held", 32'(dmem_read), 32'd1);
      check("t4 ld_resp", 32'(ld_resp), 32'd0);
      respond("t4", 1, 16'h5555, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check("t4 busy after", 32'(busy), 32'd0);
      check("t4 dmem_read after", 32'(dmem_read), 32'd0);
      tick();

      // flush arriving together with dmem_resp suppresses ld_resp
      set_ld(16'h0500); exp_ld(16'h0500);
      wait_cmd("t8");
      tick();
      flush = 1'b1; ld_read = 1'b0;
      respond("t8", 0, 16'h7777, 1'b0, 1'b0, 16'h0000);
      flush = 1'b0;
      @(negedge clk);
      check("t8 busy after", 32'(busy), 32'd0);
      tick();

      // 5: flush during ST_BUSY has no effect on the store
      set_st(16'h0600, 16'hCAFE, 2'b01); exp_st(16'h0600, 16'hCAFE, 2'b01);
      wait_cmd("t5");
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("t5 state", 32'(state), 32'd2);
      check("t5 dmem_write", 32'(dmem_write), 32'd1);
      respond("t5", 1, 16'h0000, 1'b0, 1'b1, 16'h0000);
      st_write = 1'b0;
      @(negedge clk);
      check("t5 busy after", 32'(busy), 32'd0);
      tick();

      // 6: reset during LD_BUSY abandons the load
      set_ld(16'h0700); exp_ld(16'h0700);
      wait_cmd("t6");
      tick();
      reset = 1'b1; ld_read = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t6 dmem_read", 32'(dmem_read), 32'd0);
      check("t6 busy", 32'(busy), 32'd0);
      check("t6 state", 32'(state), 32'd0);
      respond("t6", 1, 16'h9999, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check("t6 busy after", 32'(busy), 32'd0);

      check("exp_q drained", 32'(exp_q.size()), 32'd0);
      check("resp_q drained", 32'(resp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
